// File: rtl/cif_wrr_arb_pkg.sv
// Shared types and helpers for the CIF channel arbiter.
//   arb_mode_e  : arbitration mode encoding driven on arb_mode
//   eff_wgt()   : effective burst length of a channel for the given mode
//   onehot2bin(): index of the set bit of a one-hot vector (0 when empty)
package cif_arb_pkg;

  typedef enum logic [1:0] {
    ARB_RR  = 2'd0,
    ARB_WRR = 2'd1,
    ARB_FIX = 2'd2,
    ARB_RSV = 2'd3
  } arb_mode_e;

  // Upper bound on channel count accepted by onehot2bin.
  localparam int unsigned MAX_CH = 64;

  // A weight of 0 still earns one grant; only WRR uses the weight at all.
  function automatic int unsigned eff_wgt(input int unsigned w, input arb_mode_e mode);
    if (mode != ARB_WRR) return 1;
    if (w == 0) return 1;
    return w;
  endfunction

  function automatic int unsigned onehot2bin(input logic [MAX_CH-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < MAX_CH; i++) begin
      if (oh[i]) idx = unsigned'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cif_rr_pick.sv
// Combinational rotate-priority first-one picker.
//   eff_req   : eligible requests
//   start_ptr : channel that gets highest priority this scan
//   pick      : one-hot of the first set eff_req bit at start_ptr, start_ptr+1, ...
//               (modulo CH_NUM); all zero when eff_req is zero
module cif_rr_pick #(
  parameter int CH_NUM = 8,
  parameter int PTR_W  = $clog2(CH_NUM)
) (
  input  logic [CH_NUM-1:0] eff_req,
  input  logic [PTR_W-1:0]  start_ptr,
  output logic [CH_NUM-1:0] pick
);

  always_comb begin
    int  idx;
    logic found;
    pick  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < CH_NUM; i++) begin
      idx = int'(start_ptr) + i;
      if (idx >= CH_NUM) idx = idx - CH_NUM;
      if (!found && eff_req[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cif_wrr_arb.sv
// Weighted round-robin CIF channel arbiter.
//   user_clk, reset_n : clock, asynchronous active-low reset
//   req, ch_enb       : per-channel request level and enable (eff_req = req & ch_enb)
//   wgt               : packed per-channel weights, ch i at wgt[i*WGT_W +: WGT_W]
//   arb_mode          : 0 RR, 1 WRR, 2 fixed (ch0 highest), 3 behaves as RR
//   arbenb            : arbitration enable
//   gnt, gnt_anych    : registered one-hot grant pulse and its OR
//   gnt_id            : encoded granted channel (0 when no grant)
//   prio_ptr          : current highest-priority channel (debug view of the pointer state)
// A grant is evaluated only on cycles with no grant showing, so grants are at
// most every other cycle and the pointer update uses the grant currently showing.
module cif_wrr_arb
  import cif_arb_pkg::*;
#(
  parameter int CH_NUM = 8,
  parameter int WGT_W  = 4,
  localparam int ID_W  = $clog2(CH_NUM)
) (
  input  logic                    user_clk,
  input  logic                    reset_n,
  input  logic [CH_NUM-1:0]       req,
  input  logic [CH_NUM-1:0]       ch_enb,
  input  logic [CH_NUM*WGT_W-1:0] wgt,
  input  logic [1:0]              arb_mode,
  input  logic                    arbenb,
  output logic [CH_NUM-1:0]       gnt,
  output logic                    gnt_anych,
  output logic [ID_W-1:0]         gnt_id,
  output logic [ID_W-1:0]         prio_ptr
);

  arb_mode_e         mode;
  logic [CH_NUM-1:0] eff_req;
  logic [CH_NUM-1:0] pick;
  logic [ID_W-1:0]   start_ptr;
  logic [ID_W-1:0]   ptr, ptr_nxt;
  logic [WGT_W-1:0]  cnt, cnt_nxt;
  logic [WGT_W-1:0]  w_g;
  logic [ID_W-1:0]   g_succ;
  int unsigned       ew;
  int unsigned       cnt_inc;

  assign mode      = arb_mode_e'(arb_mode);
  assign eff_req   = req & ch_enb;
  assign start_ptr = (mode == ARB_FIX) ? '0 : ptr;
  assign gnt_anych = |gnt;
  assign gnt_id    = ID_W'(onehot2bin(MAX_CH'(gnt)));
  assign prio_ptr  = ptr;

  cif_rr_pick #(.CH_NUM(CH_NUM), .PTR_W(ID_W)) u_pick (
    .eff_req   (eff_req),
    .start_ptr (start_ptr),
    .pick      (pick)
  );

  // Weight of the channel currently showing a grant.
  always_comb begin
    w_g = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (gnt[i]) w_g = wgt[i*WGT_W +: WGT_W];
    end
  end

  assign g_succ  = (gnt_id == ID_W'(CH_NUM - 1)) ? '0 : gnt_id + ID_W'(1);
  assign ew      = eff_wgt(32'(w_g), mode);
  assign cnt_inc = 32'(cnt) + 32'd1;

  // Pointer/burst update, taken on the grant cycle. Mode and weight are read
  // here, so a mid-burst change takes effect at the next update; a shrunken
  // weight (ew <= cnt) makes cnt_inc >= ew and rotates immediately.
  always_comb begin
    ptr_nxt = ptr;
    cnt_nxt = cnt;
    if (gnt_anych && arbenb) begin
      if (mode == ARB_FIX) begin
        ptr_nxt = '0;
        cnt_nxt = '0;
      end else if (gnt_id == ptr) begin
        if (cnt_inc < ew) begin
          cnt_nxt = cnt + WGT_W'(1);
        end else begin
          ptr_nxt = g_succ;
          cnt_nxt = '0;
        end
      end else if (ew > 32'd1) begin
        // Pointer channel was idle: the granted channel takes over the burst.
        ptr_nxt = gnt_id;
        cnt_nxt = WGT_W'(1);
      end else begin
        ptr_nxt = g_succ;
        cnt_nxt = '0;
      end
    end
  end

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt <= '0;
      ptr <= '0;
      cnt <= '0;
    end else begin
      gnt <= (arbenb && !gnt_anych) ? pick : '0;
      ptr <= ptr_nxt;
      cnt <= cnt_nxt;
    end
  end

  a_gnt_onehot : assert property (@(posedge user_clk) disable iff (!reset_n)
    gnt_anych |-> $onehot(gnt));

endmodule

// File: tb/tb_cif_wrr_arb.sv
// Self-checking bench for cif_wrr_arb: a cycle-level reference model of the
// grant rules pushes expected grants; a negedge monitor pops and compares.
module tb_cif_wrr_arb;

  localparam int CH = 8;
  localparam int WW = 4;

  logic          user_clk = 1'b0;
  logic          reset_n  = 1'b0;
  logic [CH-1:0] req      = '0;
  logic [CH-1:0] ch_enb   = '1;
  logic [CH*WW-1:0] wgt   = '0;
  logic [1:0]    arb_mode = 2'd0;
  logic          arbenb   = 1'b1;
  logic [CH-1:0] gnt;
  logic          gnt_anych;
  logic [2:0]    gnt_id;
  logic [2:0]    prio_ptr;

  int n_checks = 0;
  int n_err    = 0;

  cif_wrr_arb #(.CH_NUM(CH), .WGT_W(WW)) dut (
    .user_clk  (user_clk),
    .reset_n   (reset_n),
    .req       (req),
    .ch_enb    (ch_enb),
    .wgt       (wgt),
    .arb_mode  (arb_mode),
    .arbenb    (arbenb),
    .gnt       (gnt),
    .gnt_anych (gnt_anych),
    .gnt_id    (gnt_id),
    .prio_ptr  (prio_ptr)
  );

  // ---------------- clock / reset ----------------
  always #5 user_clk = ~user_clk;

  task automatic cycles(input int n);
    repeat (n) @(posedge user_clk);
    #2;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    cycles(2);
    reset_n = 1'b1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // exp_q entry: {expected granted channel, expected prio_ptr during the pulse}
  logic [5:0] exp_q[$];
  int obs_q[$];
  int m_ptr, m_cnt, m_g;
  bit m_busy;

  always @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ptr = 0; m_cnt = 0; m_g = 0; m_busy = 0;
      exp_q.delete();
    end else begin
      int mode, ew, w, start;
      logic [CH-1:0] eff;
      mode = int'(arb_mode);
      eff  = req & ch_enb;
      if (m_busy && arbenb) begin
        w  = int'((wgt >> (m_g * WW)) & 32'hF);
        ew = (mode == 1) ? ((w == 0) ? 1 : w) : 1;
        if (mode == 2) begin
          m_ptr = 0; m_cnt = 0;
        end else if (m_g == m_ptr) begin
          if (m_cnt + 1 < ew) m_cnt = m_cnt + 1;
          else begin m_ptr = (m_g + 1) % CH; m_cnt = 0; end
        end else if (ew > 1) begin
          m_ptr = m_g; m_cnt = 1;
        end else begin
          m_ptr = (m_g + 1) % CH; m_cnt = 0;
        end
      end
      if (arbenb && !m_busy && eff != 0) begin
        start = (mode == 2) ? 0 : m_ptr;
        for (int i = CH - 1; i >= 0; i--) begin
          if (eff[(start + i) % CH]) m_g = (start + i) % CH;
        end
        m_busy = 1;
        exp_q.push_back({3'(m_g), 3'(m_ptr)});
      end else begin
        m_busy = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge user_clk) begin
    if (reset_n) begin
      logic [5:0] e;
      chk("anych_vs_gnt", int'(gnt_anych), int'(gnt != '0));
      if (gnt_anych || gnt != '0) begin
        obs_q.push_back(int'(gnt_id));
        if (exp_q.size() == 0) begin
          chk("unexpected_gnt", int'(gnt), 0);
        end else begin
          e = exp_q.pop_front();
          chk("gnt_vec", int'(gnt), 1 << e[5:3]);
          chk("gnt_id", int'(gnt_id), int'(e[5:3]));
          chk("prio_ptr", int'(prio_ptr), int'(e[2:0]));
        end
      end else begin
        chk("gnt_id_idle", int'(gnt_id), 0);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("missing_gnt", -1, int'(e[5:3]));
        end
      end
    end
  end

  task automatic chk_seq(input string name, input int e[$]);
    for (int i = 0; i < e.size(); i++)
      chk(name, (i < obs_q.size()) ? obs_q[i] : -1, e[i]);
  endtask

  function automatic logic [CH*WW-1:0] all_wgt(input int w);
    logic [CH*WW-1:0] v;
    for (int i = 0; i < CH; i++) v[i*WW +: WW] = WW'(w);
    return v;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int e[$];
    int found;
    int n0;

    // Reset values
    #3;
    chk("rst_gnt", int'(gnt), 0);
    chk("rst_anych", int'(gnt_anych), 0);
    chk("rst_gnt_id", int'(gnt_id), 0);
    chk("rst_ptr", int'(prio_ptr), 0);
    cycles(1);
    reset_n = 1'b1;

    // RR: full request, order 0..7 then wraps to 0
    do_reset();
    arb_mode = 2'd0; wgt = all_wgt(5); obs_q.delete();
    req = 8'hFF;
    cycles(18);
    req = '0;
    cycles(2);
    e = {0, 1, 2, 3, 4, 5, 6, 7, 0};
    chk_seq("rr_order", e);

    // WRR: ch0 weight 3, ch1 weight 1
    do_reset();
    arb_mode = 2'd1; wgt = all_wgt(2); wgt[3:0] = 4'd3; wgt[7:4] = 4'd1;
    obs_q.delete();
    req = 8'h03;
    cycles(16);
    req = '0;
    cycles(2);
    e = {0, 0, 0, 1, 0, 0, 0, 1};
    chk_seq("wrr_order", e);

    // Idle holder: ptr=2 (wgt 4), only ch5 requests
    do_reset();
    arb_mode = 2'd0; obs_q.delete();
    req = 8'h02;
    cycles(2);
    req = '0; arb_mode = 2'd1; wgt = all_wgt(4);
    cycles(1);
    chk("idle_ptr_start", int'(prio_ptr), 2);
    req = 8'h20;
    cycles(2);
    chk("idle_ptr_took", int'(prio_ptr), 5);
    req = 8'h24;
    cycles(10);
    req = '0;
    cycles(2);
    e = {1, 5, 5, 5, 5, 2};
    chk_seq("idle_order", e);

    // Fixed priority: ch2 wins over ch7 until it drops
    do_reset();
    arb_mode = 2'd2; wgt = all_wgt(3); obs_q.delete();
    req = 8'h84;
    cycles(10);
    req = 8'h80;
    cycles(4);
    req = '0;
    cycles(2);
    e = {2, 2, 2, 2, 2, 7};
    chk_seq("fix_order", e);

    // Masking: the only requester disabled
    do_reset();
    arb_mode = 2'd0; obs_q.delete();
    ch_enb = 8'hFE; req = 8'h01;
    cycles(10);
    chk("mask_no_gnt", obs_q.size(), 0);
    req = '0; ch_enb = 8'hFF;
    cycles(2);

    // arbenb low mid-stream: pending pulse completes, pointer frozen
    obs_q.delete();
    req = 8'hFF;
    cycles(5);
    arbenb = 1'b0;
    cycles(8);
    chk("arbenb_pulses", obs_q.size(), 3);
    chk("arbenb_ptr_held", int'(prio_ptr), 2);
    arbenb = 1'b1;
    cycles(4);
    req = '0;
    cycles(2);
    e = {0, 1, 2, 2};
    chk_seq("arbenb_order", e);

    // Reset while a grant shows at ptr=5
    do_reset();
    arb_mode = 2'd0; req = 8'hFF;
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      @(negedge user_clk);
      if (gnt_anych && gnt_id == 3'd5) found = 1;
    end
    chk("rst_mid_reached", found, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_gnt", int'(gnt), 0);
    chk("rst_mid_anych", int'(gnt_anych), 0);
    chk("rst_mid_ptr", int'(prio_ptr), 0);
    @(posedge user_clk);
    #2 reset_n = 1'b1;
    obs_q.delete();
    cycles(4);
    e = {0};
    chk_seq("rst_first_gnt", e);

    // Randomized traffic against the model
    n0 = n_checks;
    for (int c = 0; c < 3000; c++) begin
      if (c % 50 == 0) begin
        arb_mode = 2'($urandom_range(0, 3));
        for (int i = 0; i < CH; i++) wgt[i*WW +: WW] = WW'($urandom_range(0, 15));
      end
      req    = 8'($urandom);
      ch_enb = ($urandom_range(0, 3) != 0) ? 8'hFF : 8'($urandom);
      arbenb = ($urandom_range(0, 9) != 0);
      cycles(1);
    end
    req = '0; arbenb = 1'b1;
    cycles(3);
    chk("rand_ran", int'(n_checks > n0), 1);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
